ecc_secded_dec_pipe: RTL
========================

Name: ecc_secded_dec_pipe

Overview:
- Parametrised SEC-DED (extended Hamming) decoder; next generation of the fixed 128-bit decoder.
- Two-stage pipeline with full valid/ready backpressure, runtime correct/detect-only mode, error position/syndrome reporting, and saturating error-statistics counters.
- Sits between the memory/link read path and the consumer.
- Correction and flagging are computed per word and travel with it through the pipeline.

Parameters:
- DATA_W, 128: payload width, any value >= 4.
- CNT_W, 16: width of each statistics counter.
- Derived localparam R: the smallest R with 2^R >= DATA_W+R+1 (R=8 for 128).
- Derived localparam N = DATA_W+R+1: codeword width (137 for 128).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input word valid.
- o_ready  out  1  decoder can accept a word this cycle.
- i_code  in  N  codeword.
- i_corr_en  in  1  1=correct single errors; 0=detect only. Sampled with the word.
- o_valid  out  1  output word valid.
- i_ready  in  1  consumer accepts the output this cycle.
- o_data  out  DATA_W  decoded payload.
- o_err_corr  out  1  single error corrected.
- o_err_detec  out  1  any error detected.
- o_err_fatal  out  1  uncorrectable error.
- o_syndrome  out  R  Hamming syndrome of the word.
- o_err_pos  out  R  flipped codeword index, valid when o_err_corr=1.
- i_cnt_clr  in  1  clear both counters.
- o_cnt_corr  out  CNT_W  corrected-word count, saturating.
- o_cnt_fatal  out  CNT_W  fatal-word count, saturating.

Behaviour:
- Reset is synchronous and active-high. All outputs are 0 after reset: o_valid, flags, o_data, o_syndrome, o_err_pos, counters. Both stage-valid bits are 0. o_ready=1 in the first cycle after reset deasserts.
- Code layout:
  - Index 0 = overall parity.
  - Indices 2^k (k=0..R-1) = check bits.
  - Remaining indices, ascending = data bits d0,d1,...; for example 3->d0, 5->d1, 6->d2, 7->d3.
- Stage 1 registers the syndrome (XOR of indices 1..N-1 of all set bits), the overall parity (XOR of all N bits), the raw code and corr_en.
- Stage 2 registers data, flags, syndrome, position.
- Latency: 2 cycles from accepted input to o_valid when there is no stall.
- Handshake:
  - Input transfer: i_valid & o_ready. Output transfer: o_valid & i_ready.
  - Stage 2 advances when it is empty or i_ready=1. Stage 1 advances when it is empty or stage 2 advances.
  - o_ready = !s1_valid | s2_advance (combinational).
  - While stalled, o_data and all flags hold stable. Nothing is dropped or duplicated.
- Decode table (syn = syndrome, p = overall parity):
  - syn=0, p=0: clean. All flags 0.
  - p=1, syn<N: single error at index syn; syn=0 means the parity bit itself.
    - If corr_en=1: flip that bit; o_err_corr=1, o_err_detec=1, o_err_pos=syn.
    - If corr_en=0: data passes uncorrected; o_err_detec=1 only.
  - p=1, syn>=N: o_err_fatal=1, o_err_detec=1.
  - syn!=0, p=0: double error. o_err_fatal=1, o_err_detec=1, data uncorrected.
- Flags are meaningful only while o_valid=1 and are forced to 0 when o_valid=0.
- Counters:
  - Update on output transfer only.
  - Each saturates at 2^CNT_W-1.
  - i_cnt_clr has priority over an increment in the same cycle (result 0).
- Reset asserted mid-stream discards in-flight words. No output is produced for them.

Decomposition:
- Package ecc_pkg holds:
  - Function calc_r(DATA_W).
  - Functions data_idx(i), mapping data bit to codeword index, and is_pow2.
  - Enum err_kind_t {CLEAN, SINGLE, DOUBLE, FATAL_OOR}.
- One combinational sub-module, ecc_secded_syndrome, computes syndrome and parity from i_code. It is reusable by a future encoder checker.

Test Plan:
- Clean word: i_code=0, i_ready=1 -> after 2 cycles o_data=0, all flags 0, syndrome 0.
- Single data error: i_code=1<<5, corr_en=1 -> o_data=0, o_err_corr=1, o_err_detec=1, o_syndrome=5, o_err_pos=5, o_cnt_corr=1.
- Parity-bit error: i_code=1, corr_en=1 -> o_data=0, o_err_corr=1, o_err_pos=0. Then with corr_en=0, i_code=1<<5 -> o_data=2 (d1 set), o_err_detec=1, o_err_corr=0.
- Double error: i_code=(1<<4)|(1<<16) -> syndrome 20, p=0, o_err_fatal=1, o_err_detec=1, o_cnt_fatal increments.
- Backpressure: stream 4 words with i_ready=0 for 3 cycles -> o_ready drops after 2 words are accepted; o_data held stable; all 4 words emerge in order with no loss or duplication.
- Counter saturation/clear: CNT_W=4, 20 single-error words -> o_cnt_corr=15. Assert i_cnt_clr together with an increment -> 0. Reset mid-stream -> o_valid=0 next cycle.

Source files
------------

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types and layout helpers for the SEC-DED decoder
// Holds the error classification enum and constant functions that define
// the extended-Hamming codeword layout (check-bit count, data-bit placement).
package ecc_pkg;

    typedef enum logic [1:0] {
        CLEAN,
        SINGLE,
        DOUBLE,
        FATAL_OOR
    } err_kind_t;

    // Smallest r such that 2^r covers data, check bits and the parity bit.
    function automatic int calc_r(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < (data_w + r + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Codeword index of data bit i: data fills non-power-of-two indices
    // in ascending order starting at 3 (index 0 is overall parity).
    function automatic int data_idx(input int i);
        int idx;
        int cnt;
        idx = 0;
        cnt = -1;
        while (cnt < i) begin
            idx = idx + 1;
            if (!is_pow2(idx)) begin
                cnt = cnt + 1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ecc_secded_syndrome.sv
// rtl/ecc_secded_syndrome.sv - combinational syndrome and overall parity
// Ports: code (N-bit codeword) in; syndrome (R-bit XOR of the indices of
// set bits 1..N-1) and parity (XOR of all N bits) out.
module ecc_secded_syndrome #(
    parameter int N = 137,
    parameter int R = 8
) (
    input  logic [N-1:0] code,
    output logic [R-1:0] syndrome,
    output logic         parity
);

    always_comb begin
        syndrome = '0;
        for (int i = 1; i < N; i++) begin
            if (code[i]) begin
                syndrome = syndrome ^ R'(i);
            end
        end
        parity = ^code;
    end

endmodule

// File: rtl/ecc_secded_dec_pipe.sv
// rtl/ecc_secded_dec_pipe.sv - two-stage SEC-DED decoder with backpressure
// Stage 1 captures code, syndrome, parity and corr_en; stage 2 captures the
// decoded payload and error report. Ports: i_valid/o_ready/i_code/i_corr_en
// input handshake; o_valid/i_ready output handshake with o_data, error flags,
// o_syndrome, o_err_pos; i_cnt_clr and saturating o_cnt_corr/o_cnt_fatal.
module ecc_secded_dec_pipe
    import ecc_pkg::*;
#(
    parameter int  DATA_W = 128,
    parameter int  CNT_W  = 16,
    localparam int R      = calc_r(DATA_W),
    localparam int N      = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [N-1:0]      i_code,
    input  logic              i_corr_en,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err_corr,
    output logic              o_err_detec,
    output logic              o_err_fatal,
    output logic [R-1:0]      o_syndrome,
    output logic [R-1:0]      o_err_pos,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_cnt_corr,
    output logic [CNT_W-1:0]  o_cnt_fatal
);

    logic [R-1:0] in_syn;
    logic         in_par;

    ecc_secded_syndrome #(.N(N), .R(R)) u_syndrome (
        .code     (i_code),
        .syndrome (in_syn),
        .parity   (in_par)
    );

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic [N-1:0]      s1_code_q, s1_code_d;
    logic [R-1:0]      s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;
    logic              s1_corr_en_q, s1_corr_en_d;

    // Stage 2 state
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              s2_corr_q, s2_corr_d;
    logic              s2_detec_q, s2_detec_d;
    logic              s2_fatal_q, s2_fatal_d;
    logic [R-1:0]      s2_syn_q, s2_syn_d;
    logic [R-1:0]      s2_pos_q, s2_pos_d;

    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_fatal_q, cnt_fatal_d;

    logic s1_adv, s2_adv, out_xfer;

    assign s2_adv   = !s2_valid_q || i_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign o_ready  = s1_adv;
    assign out_xfer = s2_valid_q && i_ready;

    // Decode of the word held in stage 1
    err_kind_t         kind;
    logic              dec_corr, dec_detec, dec_fatal;
    logic [N-1:0]      code_fix;
    logic [DATA_W-1:0] dec_data;

    always_comb begin
        kind = CLEAN;
        if (s1_par_q) begin
            kind = (int'(s1_syn_q) < N) ? SINGLE : FATAL_OOR;
        end else if (s1_syn_q != '0) begin
            kind = DOUBLE;
        end
        dec_corr  = (kind == SINGLE) && s1_corr_en_q;
        dec_detec = (kind != CLEAN);
        dec_fatal = (kind == DOUBLE) || (kind == FATAL_OOR);
        code_fix  = s1_code_q;
        for (int i = 0; i < N; i++) begin
            if (dec_corr && (s1_syn_q == R'(i))) begin
                code_fix[i] = ~s1_code_q[i];
            end
        end
    end

    for (genvar g = 0; g < DATA_W; g++) begin : g_extract
        assign dec_data[g] = code_fix[data_idx(g)];
    end

    // Check and parity bits are consumed only by the syndrome logic.
    logic fix_unused;
    assign fix_unused = ^code_fix;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_code_d    = s1_code_q;
        s1_syn_d     = s1_syn_q;
        s1_par_d     = s1_par_q;
        s1_corr_en_d = s1_corr_en_q;
        if (s1_adv) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_code_d    = i_code;
                s1_syn_d     = in_syn;
                s1_par_d     = in_par;
                s1_corr_en_d = i_corr_en;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_corr_d  = s2_corr_q;
        s2_detec_d = s2_detec_q;
        s2_fatal_d = s2_fatal_q;
        s2_syn_d   = s2_syn_q;
        s2_pos_d   = s2_pos_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = dec_data;
                s2_corr_d  = dec_corr;
                s2_detec_d = dec_detec;
                s2_fatal_d = dec_fatal;
                s2_syn_d   = s1_syn_q;
                s2_pos_d   = dec_corr ? s1_syn_q : '0;
            end
        end

        // Clear wins over a same-cycle increment.
        cnt_corr_d  = cnt_corr_q;
        cnt_fatal_d = cnt_fatal_q;
        if (i_cnt_clr) begin
            cnt_corr_d  = '0;
            cnt_fatal_d = '0;
        end else if (out_xfer) begin
            if (s2_corr_q && (cnt_corr_q != '1)) begin
                cnt_corr_d = cnt_corr_q + CNT_W'(1);
            end
            if (s2_fatal_q && (cnt_fatal_q != '1)) begin
                cnt_fatal_d = cnt_fatal_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s1_corr_en_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_corr_q    <= 1'b0;
            s2_detec_q   <= 1'b0;
            s2_fatal_q   <= 1'b0;
            s2_syn_q     <= '0;
            s2_pos_q     <= '0;
            cnt_corr_q   <= '0;
            cnt_fatal_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s1_corr_en_q <= s1_corr_en_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_corr_q    <= s2_corr_d;
            s2_detec_q   <= s2_detec_d;
            s2_fatal_q   <= s2_fatal_d;
            s2_syn_q     <= s2_syn_d;
            s2_pos_q     <= s2_pos_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_fatal_q  <= cnt_fatal_d;
        end
    end

    assign o_valid     = s2_valid_q;
    assign o_data      = s2_data_q;
    assign o_err_corr  = s2_valid_q & s2_corr_q;
    assign o_err_detec = s2_valid_q & s2_detec_q;
    assign o_err_fatal = s2_valid_q & s2_fatal_q;
    assign o_syndrome  = s2_syn_q;
    assign o_err_pos   = s2_pos_q;
    assign o_cnt_corr  = cnt_corr_q;
    assign o_cnt_fatal = cnt_fatal_q;

endmodule
